vga_scan_scheduler: RTL and testbench

Master timing controller for the 640x480@60 Hz display path on the 25 MHz pixel clock. It owns the horizontal and vertical scan counters and produces registered hsync, vsync and video_on plus pixel coordinates. It also schedules one line-prefetch request per displayed line to the frame-buffer/denoise line buffer through a req/ack handshake, and flags late service as an underrun. It supports clean start and stop of scanning on frame boundaries.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/scan_axis_counter.sv | 35 +++
 rtl/vga_scan_scheduler.sv | 156 +++++++++++++++
 tb/tb_vga_scan_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, window boundaries and scan FSM state type for the
// 640x480@60 Hz display path.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } scan_state_t;

    // Inclusive window test used for the sync pulses.
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// Wrap counter for one scan axis; exposes the next count so the parent can
// register outputs that line up with the count shown in the same cycle.
module scan_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = 11
) (
    input  logic         clk_25MHz,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // Next count and wrap pulse.
    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_scan_scheduler.sv
// Master scan timing: H/V counters, registered sync/video outputs, per-line
// prefetch request handshake with underrun detection, frame-aligned start/stop.
module vga_scan_scheduler
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        run,
    output logic [10:0] h_count,
    output logic [9:0]  v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic        line_req,
    output logic [9:0]  line_req_y,
    input  logic        line_ack,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    scan_state_t state;
    scan_state_t state_next;

    logic        scanning;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic [31:0] hn;
    logic [31:0] vn;
    logic        h_wrap;
    logic        v_wrap;

    logic        scan_n;
    logic        hsync_n;
    logic        vsync_n;
    logic        video_on_n;
    logic        frame_start_n;
    logic        req_fire;
    logic [9:0]  req_y;
    logic        underrun_hit;

    assign scanning = (state != IDLE);
    assign hn       = 32'(h_next);
    assign vn       = 32'(v_next);

    scan_axis_counter #(
        .TOTAL (H_TOTAL),
        .W     (11)
    ) u_h_counter (
        .clk_25MHz  (clk_25MHz),
        .rst        (rst),
        .en         (scanning),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    scan_axis_counter #(
        .TOTAL (V_TOTAL),
        .W     (10)
    ) u_v_counter (
        .clk_25MHz  (clk_25MHz),
        .rst        (rst),
        .en         (h_wrap),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // FSM state register.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start on run, stop only at the end-of-frame wrap.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (run) state_next = RUN;
            RUN: begin
                if (v_wrap) begin
                    state_next = run ? RUN : IDLE;
                end else if (!run) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   if (v_wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next counter values so registered outputs line
    // up with the h_count/v_count shown in the same cycle.
    always_comb begin
        scan_n        = (state_next != IDLE);
        hsync_n       = !(scan_n && in_window(hn, H_SYNC_START, H_SYNC_END));
        vsync_n       = !(scan_n && in_window(vn, V_SYNC_START, V_SYNC_END));
        video_on_n    = scan_n && (hn < H_ACTIVE) && (vn < V_ACTIVE);
        frame_start_n = (state_next == RUN) && (hn == 0) && (vn == 0);
        req_fire      = scan_n && (hn == H_ACTIVE) &&
                        ((vn < V_ACTIVE - 1) ||
                         ((vn == V_TOTAL - 1) && (state_next == RUN)));
        req_y         = (vn < V_ACTIVE - 1) ? v_next + 10'd1 : '0;
        underrun_hit  = line_req && !line_ack && scan_n && (hn == 0) && (vn < V_ACTIVE);
    end

    // Registered outputs, request handshake and sticky underrun flag.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_req_y  <= '0;
            underrun    <= 1'b0;
        end else begin
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            video_on    <= video_on_n;
            frame_start <= frame_start_n;
            if (req_fire) begin
                line_req   <= 1'b1;
                line_req_y <= req_y;
            end else if (underrun_hit || (line_req && line_ack)) begin
                line_req <= 1'b0;
            end
            if (underrun_hit) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_scheduler.sv
// Bench for vga_scan_scheduler with reduced timing (30x19 frame) so whole
// frames fit in a short run.
module tb_vga_scan_scheduler;
    import vga_timing_pkg::*;

    localparam int unsigned HA = 16;
    localparam int unsigned HF = 4;
    localparam int unsigned HS = 6;
    localparam int unsigned HB = 4;
    localparam int unsigned VA = 12;
    localparam int unsigned VF = 2;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 3;
    localparam int VT = 19;

    logic        clk_25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        line_ack = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;
    logic        line_req;
    logic [9:0]  line_req_y;
    logic        underrun;

    always #20 clk_25MHz = ~clk_25MHz;

    vga_scan_scheduler #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .rst          (rst),
        .run          (run),
        .h_count      (h_count),
        .v_count      (v_count),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .line_req     (line_req),
        .line_req_y   (line_req_y),
        .line_ack     (line_ack),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    typedef struct { int y; int h; int v; } req_t;
    typedef struct { int k; int h; int v; int hs; int vs; int vo; int fs; } vec_t;

    req_t sb[$];
    vec_t tbl[16];

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;
    int vo_cnt   = 0;
    int fs_cnt   = 0;
    bit ack_en   = 1'b1;
    int skip_y   = 1023;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_25MHz);
        cur++;
        vo_cnt += int'(video_on);
        fs_cnt += int'(frame_start);
    endtask

    task automatic goto(input int k);
        while (cur < k) step();
    endtask

    task automatic push_frame(input bit with_zero);
        for (int y = 1; y < int'(VA); y++) sb.push_back('{y, int'(HA), y - 1});
        if (with_zero) sb.push_back('{0, int'(HA), VT - 1});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_h"}, int'(h_count), 0);
        chk({tag, "_v"}, int'(v_count), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_video_on"}, int'(video_on), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_line_req"}, int'(line_req), 0);
        chk({tag, "_line_req_y"}, int'(line_req_y), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_state"}, int'(dut.state), int'(IDLE));
    endtask

    // Request scoreboard and acknowledge responder.
    initial begin
        bit req_prev = 1'b0;
        int age = 0;
        forever begin
            @(negedge clk_25MHz);
            if (line_req && !req_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got y=%0d at h=%0d v=%0d, expected no request",
                             line_req_y, h_count, v_count);
                end else begin
                    chk("req_y", int'(line_req_y), sb[0].y);
                    chk("req_h", int'(h_count), sb[0].h);
                    chk("req_v", int'(v_count), sb[0].v);
                    sb.delete(0);
                end
            end
            req_prev = line_req;
            if (!line_req) begin
                age = 0;
                line_ack = 1'b0;
            end else begin
                age++;
                line_ack = ack_en && (age == 3) && (int'(line_req_y) != skip_y);
            end
        end
    end

    initial begin
        //            k    h   v  hs vs vo fs
        tbl[0]  = '{  0,   0,  0, 1, 1, 1, 1};
        tbl[1]  = '{ 15,  15,  0, 1, 1, 1, 0};
        tbl[2]  = '{ 16,  16,  0, 1, 1, 0, 0};
        tbl[3]  = '{ 19,  19,  0, 1, 1, 0, 0};
        tbl[4]  = '{ 20,  20,  0, 0, 1, 0, 0};
        tbl[5]  = '{ 25,  25,  0, 0, 1, 0, 0};
        tbl[6]  = '{ 26,  26,  0, 1, 1, 0, 0};
        tbl[7]  = '{ 30,   0,  1, 1, 1, 1, 0};
        tbl[8]  = '{335,   5, 11, 1, 1, 1, 0};
        tbl[9]  = '{360,   0, 12, 1, 1, 0, 0};
        tbl[10] = '{372,  12, 12, 1, 1, 0, 0};
        tbl[11] = '{390,   0, 13, 1, 1, 0, 0};
        tbl[12] = '{420,   0, 14, 1, 0, 0, 0};
        tbl[13] = '{472,  22, 15, 0, 0, 0, 0};
        tbl[14] = '{480,   0, 16, 1, 1, 0, 0};
        tbl[15] = '{569,  29, 18, 1, 1, 0, 0};

        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        step();
        step();
        chk("idle_h", int'(h_count), 0);
        chk("idle_frame_start", int'(frame_start), 0);
        chk("idle_video_on", int'(video_on), 0);

        // Frame 1: timing table, requests acked after 3 cycles.
        push_frame(1'b1);
        run = 1'b1;
        step();
        cur = 0;
        vo_cnt = int'(video_on);
        fs_cnt = int'(frame_start);
        for (int i = 0; i < 16; i++) begin
            goto(tbl[i].k);
            chk("tbl_h", int'(h_count), tbl[i].h);
            chk("tbl_v", int'(v_count), tbl[i].v);
            chk("tbl_hsync", int'(hsync), tbl[i].hs);
            chk("tbl_vsync", int'(vsync), tbl[i].vs);
            chk("tbl_video_on", int'(video_on), tbl[i].vo);
            chk("tbl_frame_start", int'(frame_start), tbl[i].fs);
        end
        chk("video_on_count", vo_cnt, int'(HA * VA));
        chk("frame_start_count", fs_cnt, 1);
        chk("f1_underrun", int'(underrun), 0);
        chk("f1_reqs_left", sb.size(), 0);
        step();
        chk("period_frame_start", int'(frame_start), 1);
        chk("period_h", int'(h_count), 0);
        chk("period_v", int'(v_count), 0);

        // Frame 2: withhold acks for y=5 and then y=8.
        push_frame(1'b1);
        skip_y = 5;
        goto(719);
        chk("pre_ur_underrun", int'(underrun), 0);
        chk("pre_ur_line_req", int'(line_req), 1);
        goto(720);
        chk("ur_underrun", int'(underrun), 1);
        chk("ur_line_req", int'(line_req), 0);
        chk("ur_h", int'(h_count), 0);
        chk("ur_v", int'(v_count), 5);
        skip_y = 8;
        goto(750);
        chk("ur_sticky", int'(underrun), 1);
        goto(790);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur_cleared", int'(underrun), 0);
        goto(809);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur_set_beats_clr", int'(underrun), 1);
        chk("ur2_line_req", int'(line_req), 0);
        step();
        chk("ur2_sticky", int'(underrun), 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur2_cleared", int'(underrun), 0);
        skip_y = 1023;
        goto(1139);
        chk("f2_reqs_left", sb.size(), 0);
        step();
        chk("f3_frame_start", int'(frame_start), 1);

        // Frame 3: drop run mid-frame, pulse it inside the drain.
        push_frame(1'b0);
        goto(1330);
        run = 1'b0;
        goto(1400);
        run = 1'b1;
        goto(1410);
        run = 1'b0;
        goto(1696);
        chk("drain_no_req", int'(line_req), 0);
        goto(1709);
        chk("drain_last_h", int'(h_count), 29);
        chk("drain_last_v", int'(v_count), 18);
        step();
        chk("drain_idle_h", int'(h_count), 0);
        chk("drain_idle_v", int'(v_count), 0);
        chk("drain_idle_hsync", int'(hsync), 1);
        chk("drain_idle_vsync", int'(vsync), 1);
        chk("drain_idle_video_on", int'(video_on), 0);
        chk("drain_idle_frame_start", int'(frame_start), 0);
        step();
        step();
        chk("idle_hold_h", int'(h_count), 0);
        chk("idle_hold_line_req", int'(line_req), 0);
        chk("f3_reqs_left", sb.size(), 0);

        // Frame 4: restart, leave requests unserviced, reset mid-frame.
        push_frame(1'b1);
        run = 1'b1;
        step();
        chk("restart_frame_start", int'(frame_start), 1);
        cur = 0;
        ack_en = 1'b0;
        goto(115);
        chk("pend_line_req", int'(line_req), 1);
        chk("pend_line_req_y", int'(line_req_y), 4);
        chk("pend_underrun", int'(underrun), 1);
        rst = 1'b1;
        run = 1'b0;
        step();
        check_reset("midrst");
        rst = 1'b0;
        sb.delete();
        ack_en = 1'b1;
        step();
        step();
        chk("post_rst_h", int'(h_count), 0);
        chk("post_rst_frame_start", int'(frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
